tileng_prep_sequencer: RTL

Per-scanline controller that sequences the BG and FG tile engines through their row-prep phase, one after the other. It owns the shared single Tile-RAM and Pattern-RAM read ports during prep and multiplexes each engine's addresses onto them. It also latches each layer's double-buffered scroll register at VBLANK and tells the pixel mixer when both layers hold valid row data. It sits in ppu_logic, between the scanline timing source, the two tile_engine instances and VRAM.

---
 rtl/ppu_pkg.sv | 27 ++
 rtl/prep_watchdog.sv | 50 +++++
 rtl/tileng_prep_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU scanline-prep logic.
//   prep_state_t : prep sequencer FSM states
//   ENG_BG/ENG_FG: engine index constants (which tile engine owns VRAM)
//   prep_owner() : maps a sequencer state to the engine granted the VRAM ports
package ppu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BG_RUN = 2'd1,
        ST_FG_RUN = 2'd2,
        ST_FINISH = 2'd3
    } prep_state_t;

    localparam logic ENG_BG = 1'b0;
    localparam logic ENG_FG = 1'b1;

    // The fg engine owns VRAM only while it is prepping; bg is the default owner.
    function automatic logic prep_owner(input prep_state_t st);
        logic owner;
        case (st)
            ST_FG_RUN: owner = ENG_FG;
            default:   owner = ENG_BG;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/prep_watchdog.sv
// prep_watchdog: per-engine prep watchdog for tileng_prep_sequencer.
// Only exists when PPU_PREP_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : restart the count (asserted alongside each prep pulse)
//   run_i       : an engine is prepping, count this cycle
//   expired_o   : count has reached TIMEOUT_CYCLES while running
`ifdef PPU_PREP_TIMEOUT_EN
module prep_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 10) ? 10 : CW_RAW;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, saturate at the limit so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CW{1'b0}};
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LIMIT);

endmodule
`endif

// File: rtl/tileng_prep_sequencer.sv
// tileng_prep_sequencer: per-scanline controller that runs the BG then FG
// tile engine row-prep, muxes their addresses onto the shared Tile-RAM and
// Pattern-RAM read ports, latches scroll registers at VBLANK and flags when
// a row is ready.
// Optional feature macro: PPU_PREP_TIMEOUT_EN (per-engine prep watchdog).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   row_start                       pulse: start prep for next scanline
//   vblank                          vertical blanking level
//   bg/fg_scroll_in -> bg/fg_scroll shadow -> active scroll values
//   bg_prep, fg_prep                one-cycle prep pulses to the engines
//   bg_done, fg_done                one-cycle done pulses from the engines
//   bg/fg_tilram_addr, bg/fg_patram_addr  engine VRAM addresses
//   tilram_addr, patram_addr        shared VRAM read-port addresses
//   busy, row_ready                 sequence in flight / both layers ready
//   overrun, timeout                sticky error flags, cleared at vblank rise
module tileng_prep_sequencer
    import ppu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        row_start,
    input  logic        vblank,
    input  logic [31:0] bg_scroll_in,
    input  logic [31:0] fg_scroll_in,
    output logic [31:0] bg_scroll,
    output logic [31:0] fg_scroll,
    output logic        bg_prep,
    output logic        fg_prep,
    input  logic        bg_done,
    input  logic        fg_done,
    input  logic [10:0] bg_tilram_addr,
    input  logic [10:0] fg_tilram_addr,
    input  logic [11:0] bg_patram_addr,
    input  logic [11:0] fg_patram_addr,
    output logic [10:0] tilram_addr,
    output logic [11:0] patram_addr,
    output logic        busy,
    output logic        row_ready,
    output logic        overrun,
    output logic        timeout
);

    prep_state_t state_q, state_d;
    logic        bg_prep_q, bg_prep_d;
    logic        fg_prep_q, fg_prep_d;
    logic        row_ready_q, row_ready_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic        latch_pend_q, latch_pend_d;
    logic [31:0] bg_scroll_q, bg_scroll_d;
    logic [31:0] fg_scroll_q, fg_scroll_d;
    logic        vblank_q;
    logic        vb_rise_s;
    logic        wd_expired_s;

    assign vb_rise_s = vblank && !vblank_q;

`ifdef PPU_PREP_TIMEOUT_EN
    logic wd_clear_s;
    logic wd_run_s;

    // The count restarts on the same edge that issues a prep pulse, so the
    // engine gets exactly TIMEOUT_CYCLES cycles counted from its prep cycle.
    assign wd_clear_s = bg_prep_d || fg_prep_d;
    assign wd_run_s   = (state_q == ST_BG_RUN) || (state_q == ST_FG_RUN);

    prep_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_prep_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear_s),
        .run_i     (wd_run_s),
        .expired_o (wd_expired_s)
    );
`else
    logic [31:0] unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = 32'(TIMEOUT_CYCLES);
    assign wd_expired_s         = 1'b0;
`endif

    // Next-state, pulse generation, sticky flags and scroll latch.
    always_comb begin
        state_d      = state_q;
        bg_prep_d    = 1'b0;
        fg_prep_d    = 1'b0;
        row_ready_d  = 1'b0;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;
        latch_pend_d = latch_pend_q;
        bg_scroll_d  = bg_scroll_q;
        fg_scroll_d  = fg_scroll_q;

        // Flags clear at vblank rise; a same-cycle event below re-sets them.
        if (vb_rise_s) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
            timeout_d = timeout_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (row_start) begin
                    state_d   = ST_BG_RUN;
                    bg_prep_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BG_RUN: begin
                // A real done in the expiry cycle counts as normal completion.
                if (bg_done) begin
                    state_d   = ST_FG_RUN;
                    fg_prep_d = 1'b1;
                end else if (wd_expired_s) begin
                    state_d   = ST_FG_RUN;
                    fg_prep_d = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_BG_RUN;
                end
            end
            ST_FG_RUN: begin
                if (fg_done) begin
                    state_d     = ST_FINISH;
                    row_ready_d = 1'b1;
                end else if (wd_expired_s) begin
                    state_d     = ST_FINISH;
                    row_ready_d = 1'b1;
                    timeout_d   = 1'b1;
                end else begin
                    state_d = ST_FG_RUN;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // FINISH counts as busy, so a start on the way back to IDLE is dropped.
        if (row_start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_d;
        end

        // Scroll only moves while idle, keeping it stable across a whole prep.
        if ((state_q == ST_IDLE) && latch_pend_q) begin
            bg_scroll_d  = bg_scroll_in;
            fg_scroll_d  = fg_scroll_in;
            latch_pend_d = 1'b0;
        end else begin
            bg_scroll_d  = bg_scroll_q;
            fg_scroll_d  = fg_scroll_q;
        end

        if (vb_rise_s) begin
            latch_pend_d = 1'b1;
        end else begin
            latch_pend_d = latch_pend_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bg_prep_q    <= 1'b0;
            fg_prep_q    <= 1'b0;
            row_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            latch_pend_q <= 1'b0;
            bg_scroll_q  <= 32'h0000_0000;
            fg_scroll_q  <= 32'h0000_0000;
            vblank_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bg_prep_q    <= bg_prep_d;
            fg_prep_q    <= fg_prep_d;
            row_ready_q  <= row_ready_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            latch_pend_q <= latch_pend_d;
            bg_scroll_q  <= bg_scroll_d;
            fg_scroll_q  <= fg_scroll_d;
            vblank_q     <= vblank;
        end
    end

    // VRAM grant follows the registered state so it switches with the prep pulse.
    always_comb begin
        if (prep_owner(state_q) == ENG_FG) begin
            tilram_addr = fg_tilram_addr;
            patram_addr = fg_patram_addr;
        end else begin
            tilram_addr = bg_tilram_addr;
            patram_addr = bg_patram_addr;
        end
    end

    assign bg_prep   = bg_prep_q;
    assign fg_prep   = fg_prep_q;
    assign row_ready = row_ready_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;
    assign bg_scroll = bg_scroll_q;
    assign fg_scroll = fg_scroll_q;

endmodule
